// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M-stage port: serialized accesses with WAIT_CYCLES wait states.
// Optional macro DMEM_ERR_EN adds mem_err and rejects out-of-range addresses.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
`ifdef DMEM_ERR_EN
    output logic        mem_err,
`endif
    output logic        mem_stall
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [LANES-1:0]    wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem_array [DEPTH];

    logic [DATA_W-1:0]   c_addr;
    logic [LANES-1:0]    c_wen;
    logic [DATA_W-1:0]   c_wdata;
    logic [ADDR_W-1:0]   idx_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic [DATA_W-1:0]   merged_c;
    logic                commit_c;
    logic                err_c;
    logic                we_c;

    // State and request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mem_en) state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            S_WAIT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the accept edge is also the commit edge, so commit from the live inputs
    always_comb begin
        if (state_q == S_IDLE) begin
            c_addr  = mem_addr;
            c_wen   = mem_wen;
            c_wdata = mem_wdata;
        end else begin
            c_addr  = addr_q;
            c_wen   = wen_q;
            c_wdata = wdata_q;
        end
        idx_c     = c_addr[ADDR_W+1:2];
        rd_word_c = mem_array[idx_c];
        for (int i = 0; i < int'(LANES); i++) begin
            merged_c[8*i +: 8] = c_wen[i] ? c_wdata[8*i +: 8] : rd_word_c[8*i +: 8];
        end
        commit_c = rst && (state_q != S_DONE) && (state_d == S_DONE);
        we_c     = commit_c && (c_wen != '0) && !err_c;
    end

`ifdef DMEM_ERR_EN
    logic err_q, err_d;
    logic unused_c;

    assign err_c    = |c_addr[DATA_W-1:ADDR_W+2];
    assign err_d    = commit_c && err_c;
    assign mem_err  = err_q;
    assign unused_c = ^c_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`else
    logic unused_c;

    assign err_c    = 1'b0;
    assign unused_c = ^{c_addr[DATA_W-1:ADDR_W+2], c_addr[1:0]};
`endif

    // Output, counter and request-latch logic
    always_comb begin
        mem_stall = 1'b0;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    mem_stall = 1'b1;
                    cnt_d     = CNT_W'(WAIT_CYCLES);
                    addr_d    = mem_addr;
                    wen_d     = mem_wen;
                    wdata_d   = mem_wdata;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
        if (commit_c) rdata_d = err_c ? 32'hDEAD_BEEF : merged_c;
    end

    // Storage array has no reset; only enabled lanes are written
    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (c_wen[i]) mem_array[idx_c][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
// Expected responses are queued at request time and checked in the DONE cycle.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    logic        en2, en0;
    logic [3:0]  wen2, wen0;
    logic [31:0] addr2, addr0, wdata2, wdata0;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0;
`ifdef DMEM_ERR_EN
    logic        err2, err0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        int          stall_n;
        bit          err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_en(en2), .mem_wen(wen2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_rdata(rdata2),
`ifdef DMEM_ERR_EN
        .mem_err(err2),
`endif
        .mem_stall(stall2)
    );

    dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_en(en0), .mem_wen(wen0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0),
`ifdef DMEM_ERR_EN
        .mem_err(err0),
`endif
        .mem_stall(stall0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            en2 = en; wen2 = wen; addr2 = addr; wdata2 = wdata;
        end else begin
            en0 = en; wen0 = wen; addr0 = addr; wdata0 = wdata;
        end
    endtask

    // One request; optionally retargets the address once the request sits in WAIT
    task automatic access(input bit sel, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input int exp_stall, input bit exp_err, input bit chg,
                          input logic [31:0] chg_addr, input string tag);
        exp_t e;
        exp_t got;
        int   n;
        bit   done;
        e.rdata = exp_rdata; e.stall_n = exp_stall; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        drive(sel, 1'b1, wen, addr, wdata);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if ((sel ? stall2 : stall0) === 1'b1) begin
                n++;
                if (chg && n == 1) begin
                    @(posedge clk); #1;
                    drive(sel, 1'b1, wen, chg_addr, ~wdata);
                end
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout: observed stall stuck, expected DONE within 20 cycles", tag);
        end
        if (done) begin
            got = sb.pop_front();
            check({tag, "_rdata"}, sel ? rdata2 : rdata0, got.rdata);
            check({tag, "_stall_cycles"}, 32'(n), 32'(got.stall_n));
`ifdef DMEM_ERR_EN
            check({tag, "_err"}, 32'(sel ? err2 : err0), 32'(got.err));
`endif
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall2", 32'(stall2), 32'd0);
        check("reset_rdata2", rdata2, 32'h0);
        check("reset_stall0", 32'(stall0), 32'd0);
        check("reset_rdata0", rdata0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset landing mid-WAIT must drop the pending write
        access(1'b1, 4'hF, 32'h10, 32'h5555_AAAA, 32'h5555_AAAA, 3, 1'b0, 1'b0, 32'h0, "wr10");
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'h1122_3344);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("midwait_rst_stall", 32'(stall2), 32'd0);
        check("midwait_rst_rdata", rdata2, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        access(1'b1, 4'h0, 32'h10, 32'h0, 32'h5555_AAAA, 3, 1'b0, 1'b0, 32'h0, "rd10_after_rst");

        access(1'b1, 4'hF, 32'h40, 32'hCAFE_BABE, 32'hCAFE_BABE, 3, 1'b0, 1'b0, 32'h0, "wr40");
        access(1'b1, 4'h0, 32'h40, 32'h0, 32'hCAFE_BABE, 3, 1'b0, 1'b0, 32'h0, "rd40");
        access(1'b1, 4'hF, 32'h44, 32'h1234_5678, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0, "wr44");
        access(1'b1, 4'h0, 32'h40, 32'h0, 32'hCAFE_BABE, 3, 1'b0, 1'b1, 32'h44, "rd40_addr_change");

        access(1'b1, 4'hF, 32'h80, 32'hAABB_CCDD, 32'hAABB_CCDD, 3, 1'b0, 1'b0, 32'h0, "wr80");
        access(1'b1, 4'b0100, 32'h80, 32'h00EE_0000, 32'hAAEE_CCDD, 3, 1'b0, 1'b0, 32'h0, "wr80_lane2");
        access(1'b1, 4'h0, 32'h80, 32'h0, 32'hAAEE_CCDD, 3, 1'b0, 1'b0, 32'h0, "rd80");
        access(1'b1, 4'b1001, 32'h82, 32'h1100_0022, 32'h11EE_CC22, 3, 1'b0, 1'b0, 32'h0, "wr82_lanes03");
        access(1'b1, 4'h0, 32'h83, 32'h0, 32'h11EE_CC22, 3, 1'b0, 1'b0, 32'h0, "rd83");

        // Zero wait states, requests held continuously
        access(1'b0, 4'hF, 32'h0, 32'h0101_0101, 32'h0101_0101, 1, 1'b0, 1'b0, 32'h0, "z_wr0");
        access(1'b0, 4'hF, 32'h4, 32'h0202_0202, 32'h0202_0202, 1, 1'b0, 1'b0, 32'h0, "z_wr4");
        e.rdata = 32'h0101_0101; e.stall_n = 1; e.err = 1'b0; sb.push_back(e);
        e.rdata = 32'h0202_0202; sb.push_back(e);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("b2b_stall_a", 32'(stall0), 32'd1);
        @(negedge clk);
        check("b2b_stall_b", 32'(stall0), 32'd0);
        e = sb.pop_front();
        check("b2b_rdata_0", rdata0, e.rdata);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'h0, 32'h4, 32'h0);
        @(negedge clk);
        check("b2b_stall_c", 32'(stall0), 32'd1);
        @(negedge clk);
        check("b2b_stall_d", 32'(stall0), 32'd0);
        e = sb.pop_front();
        check("b2b_rdata_4", rdata0, e.rdata);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Address bits beyond the array
        access(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 3, 1'b0, 1'b0, 32'h0, "wr0");
`ifdef DMEM_ERR_EN
        access(1'b1, 4'hF, 32'h0001_0000, 32'h7777_7777, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, 32'h0, "wr_hi");
        @(negedge clk);
        check("err_one_cycle", 32'(err2), 32'd0);
        access(1'b1, 4'h0, 32'h0, 32'h0, 32'h0BAD_F00D, 3, 1'b0, 1'b0, 32'h0, "rd0_after_hi");
`else
        access(1'b1, 4'hF, 32'h0001_0000, 32'h7777_7777, 32'h7777_7777, 3, 1'b0, 1'b0, 32'h0, "wr_hi");
        access(1'b1, 4'h0, 32'h0, 32'h0, 32'h7777_7777, 3, 1'b0, 1'b0, 32'h0, "rd0_after_hi");
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
